writeback_stage: RTL and testbench

Final pipeline stage of the CPU, on the opposite side of the datapath from the ALU operand muxes: it takes results leaving the memory stage and returns them to the register file. It selects between ALU result and load data, extracts and sign/zero-extends sub-word loads, and suppresses writes to register 0. It also waits on a multi-cycle data memory with stall and timeout.

---
 rtl/writeback_pkg.sv | 24 ++
 rtl/load_extend.sv | 54 +++++
 rtl/writeback_stage.sv | 179 +++++++++++++++++
 tb/tb_writeback_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : writeback_pkg
// Brief   : Shared encodings, state type and sizes for the writeback stage.
// Revision: 1.0 - initial release
// ============================================================================
package writeback_pkg;

    localparam logic [1:0] LOAD_WORD = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_BYTE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wide enough for any MEM_TIMEOUT in 1..255
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module  : load_extend
// Brief   : Sub-word load extraction, sign/zero extension and misalign check.
// Revision: 1.0 - initial release
// ============================================================================
module load_extend
    import writeback_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        case (offset)
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase
        half_val = offset[1] ? word[31:16] : word[15:0];
    end

    // Reserved size encoding falls through to the word path
    always_comb begin
        data     = word;
        misalign = 1'b0;
        case (size)
            LOAD_HALF: begin
                data     = zero_ext ? {16'h0000, half_val}
                                    : {{16{half_val[15]}}, half_val};
                misalign = offset[0];
            end
            LOAD_BYTE: begin
                data     = zero_ext ? {24'h000000, byte_val}
                                    : {{24{byte_val[7]}}, byte_val};
                misalign = 1'b0;
            end
            default: begin
                data     = word;
                misalign = (offset != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : writeback_stage
// Brief   : Final pipeline stage; selects ALU/load data, waits on slow memory
//           with timeout and writes the register file. Optional forwarding
//           outputs are enabled by defining WRITEBACK_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ready_i,
    input  logic        mem_read_ctrl_i,
    input  logic        mem_to_reg_ctrl_i,
    input  logic        reg_write_ctrl_i,
    input  logic [4:0]  write_reg_addr_i,
    input  logic [1:0]  load_size_ctrl_i,
    input  logic        load_unsigned_ctrl_i,
    output logic        stall_o,
    output logic        reg_write_en_o,
    output logic [4:0]  reg_write_addr_o,
    output logic [31:0] reg_write_data_o,
    output logic        misalign_o,
    output logic        timeout_o
`ifdef WRITEBACK_BYPASS_EN
    ,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_addr_o,
    output logic [31:0] fwd_data_o
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    wb_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             capture, commit, expire;

    logic [31:0] lat_alu;
    logic        lat_mem_to_reg;
    logic        lat_reg_write;
    logic [4:0]  lat_addr;
    logic [1:0]  lat_size;
    logic        lat_zero_ext;

    logic        in_wait;
    logic [31:0] sel_alu;
    logic        sel_mem_to_reg;
    logic        sel_reg_write;
    logic [4:0]  sel_addr;
    logic [1:0]  sel_size;
    logic        sel_zero_ext;

    logic [31:0] ext_data;
    logic        ext_misalign;
    logic        bad_align;
    logic [31:0] wr_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        commit     = 1'b0;
        expire     = 1'b0;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (mem_read_ctrl_i && !mem_ready_i) begin
                        capture    = 1'b1;
                        stall_o    = 1'b1;
                        state_next = WAIT_MEM;
                        cnt_next   = '0;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                stall_o = 1'b1;
                if (mem_ready_i) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_alu        <= '0;
            lat_mem_to_reg <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_addr       <= '0;
            lat_size       <= '0;
            lat_zero_ext   <= 1'b0;
        end else if (capture) begin
            lat_alu        <= alu_result_i;
            lat_mem_to_reg <= mem_to_reg_ctrl_i;
            lat_reg_write  <= reg_write_ctrl_i;
            lat_addr       <= write_reg_addr_i;
            lat_size       <= load_size_ctrl_i;
            lat_zero_ext   <= load_unsigned_ctrl_i;
        end
    end

    // While waiting, the latched instruction is committed with live read data
    assign in_wait        = (state == WAIT_MEM);
    assign sel_alu        = in_wait ? lat_alu        : alu_result_i;
    assign sel_mem_to_reg = in_wait ? lat_mem_to_reg : mem_to_reg_ctrl_i;
    assign sel_reg_write  = in_wait ? lat_reg_write  : reg_write_ctrl_i;
    assign sel_addr       = in_wait ? lat_addr       : write_reg_addr_i;
    assign sel_size       = in_wait ? lat_size       : load_size_ctrl_i;
    assign sel_zero_ext   = in_wait ? lat_zero_ext   : load_unsigned_ctrl_i;

    load_extend u_load_extend (
        .word     (mem_data_i),
        .offset   (sel_alu[1:0]),
        .size     (sel_size),
        .zero_ext (sel_zero_ext),
        .data     (ext_data),
        .misalign (ext_misalign)
    );

    assign bad_align = sel_mem_to_reg && ext_misalign;
    assign wr_data   = sel_mem_to_reg ? ext_data : sel_alu;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_write_en_o   <= 1'b0;
            reg_write_addr_o <= '0;
            reg_write_data_o <= '0;
            misalign_o       <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            reg_write_en_o <= commit && sel_reg_write
                              && (sel_addr != REG_ZERO) && !bad_align;
            misalign_o     <= commit && bad_align;
            if (commit) begin
                reg_write_addr_o <= sel_addr;
                reg_write_data_o <= wr_data;
            end
            if (expire) begin
                timeout_o <= 1'b1;
            end
        end
    end

`ifdef WRITEBACK_BYPASS_EN
    assign fwd_valid_o = reg_write_en_o;
    assign fwd_addr_o  = reg_write_addr_o;
    assign fwd_data_o  = reg_write_data_o;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_writeback_stage
// Brief   : Self-checking bench: directed vector table, multi-cycle corner
//           sequences and randomized transactions against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int MEM_TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        ready;
    logic        rd;
    logic        m2r;
    logic        rw;
    logic [4:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic        stall;
    logic        en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
    logic        tmo;
`ifdef WRITEBACK_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    writeback_stage #(.MEM_TIMEOUT(MEM_TO)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .valid_i              (valid),
        .alu_result_i         (alu),
        .mem_data_i           (mem),
        .mem_ready_i          (ready),
        .mem_read_ctrl_i      (rd),
        .mem_to_reg_ctrl_i    (m2r),
        .reg_write_ctrl_i     (rw),
        .write_reg_addr_i     (addr),
        .load_size_ctrl_i     (size),
        .load_unsigned_ctrl_i (uns),
        .stall_o              (stall),
        .reg_write_en_o       (en),
        .reg_write_addr_o     (waddr),
        .reg_write_data_o     (wdata),
        .misalign_o           (mis),
        .timeout_o            (tmo)
`ifdef WRITEBACK_BYPASS_EN
        ,
        .fwd_valid_o          (fwd_valid),
        .fwd_addr_o           (fwd_addr),
        .fwd_data_o           (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: specification rules with plain arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] m,
                                  input logic [1:0] sz, input logic u,
                                  input logic to_reg, input logic wr, input logic [4:0] ad,
                                  output logic e_en, output logic e_mis, output logic [31:0] e_data);
        int unsigned off;
        logic [31:0] ext;
        logic bad;
        off = a & 32'd3;
        if (sz == 2'd2) begin
            ext = (m >> (8 * off)) & 32'hFF;
            if (!u && ext >= 32'h80) ext = ext + 32'hFFFF_FF00;
            bad = 1'b0;
        end else if (sz == 2'd1) begin
            ext = (m >> (16 * (off / 2))) & 32'hFFFF;
            if (!u && ext >= 32'h8000) ext = ext + 32'hFFFF_0000;
            bad = (off % 2) != 0;
        end else begin
            ext = m;
            bad = (off != 0);
        end
        e_mis  = to_reg && bad;
        e_en   = wr && (ad != 0) && !e_mis;
        e_data = to_reg ? ext : a;
    endfunction

    typedef struct packed {
        logic        rd;
        logic        m2r;
        logic        rw;
        logic [4:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        exp_en;
        logic        exp_mis;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic        e_en, e_mis, sticky, timed;
        logic [31:0] e_data, final_mem;
        int          writes, k, ncyc;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 5'd5,  2'd0, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 32'h1234_5678};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd0,  2'd0, 1'b0, 32'h0000_AAAA, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 5'd3,  2'd2, 1'b0, 32'h0000_0103, 32'h80FF_0011, 1'b1, 1'b0, 32'hFFFF_FF80};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 5'd3,  2'd2, 1'b1, 32'h0000_0103, 32'h80FF_0011, 1'b1, 1'b0, 32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 5'd4,  2'd1, 1'b0, 32'h0000_0202, 32'h8001_1234, 1'b1, 1'b0, 32'hFFFF_8001};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 5'd4,  2'd1, 1'b0, 32'h0000_0201, 32'h8001_1234, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 5'd6,  2'd0, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 5'd6,  2'd0, 1'b0, 32'h0000_0402, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 5'd8,  2'd2, 1'b0, 32'h0000_0001, 32'h1234_8056, 1'b1, 1'b0, 32'hFFFF_FF80};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 5'd9,  2'd1, 1'b1, 32'h0000_0000, 32'h0000_F00F, 1'b1, 1'b0, 32'h0000_F00F};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 5'd10, 2'd3, 1'b0, 32'h0000_0000, 32'h1122_3344, 1'b1, 1'b0, 32'h1122_3344};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd11, 2'd0, 1'b0, 32'h5555_0000, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 5'd31, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 1'b0, 32'h0000_0003};

        rst = 1'b1; valid = 1'b0; alu = '0; mem = '0; ready = 1'b0;
        rd = 1'b0; m2r = 1'b0; rw = 1'b0; addr = '0; size = '0; uns = 1'b0;

        // Reset state
        #12;
        chk("rst_en", en, 0);
        chk("rst_addr", waddr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_mis", mis, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        tick();
        chk("idle_en", en, 0);

        // Directed single-cycle vectors
        for (int i = 0; i < 13; i++) begin
            valid = 1'b1; ready = 1'b1;
            rd = vecs[i].rd; m2r = vecs[i].m2r; rw = vecs[i].rw; addr = vecs[i].addr;
            size = vecs[i].size; uns = vecs[i].uns; alu = vecs[i].alu; mem = vecs[i].mem;
            #1 chk($sformatf("vec%0d_stall", i), stall, 0);
            tick();
            chk($sformatf("vec%0d_en", i), en, vecs[i].exp_en);
            chk($sformatf("vec%0d_mis", i), mis, vecs[i].exp_mis);
            if (vecs[i].exp_en) begin
                chk($sformatf("vec%0d_addr", i), waddr, vecs[i].addr);
                chk($sformatf("vec%0d_data", i), wdata, vecs[i].exp_data);
            end
            valid = 1'b0;
        end
        #1;
        tick();
        chk("pulse_end_en", en, 0);

        // Load waiting three cycles for memory
        rd = 1'b1; m2r = 1'b1; rw = 1'b1; addr = 5'd7; size = 2'd0; uns = 1'b0; alu = 32'h100;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            valid = (i <= 3);
            ready = (i == 3);
            mem   = (i == 3) ? 32'hDEAD_BEEF : $urandom;
            #1 chk($sformatf("wait_stall%0d", i), stall, (i <= 3));
            tick();
            chk($sformatf("wait_en%0d", i), en, (i == 3));
            if (en) begin
                writes++;
                chk("wait_addr", waddr, 7);
                chk("wait_data", wdata, 32'hDEAD_BEEF);
            end
        end
        chk("wait_writes", writes, 1);

        // Reset asserted mid-wait aborts the load
        valid = 1'b1; rd = 1'b1; m2r = 1'b1; rw = 1'b1; addr = 5'd9; alu = 32'h0; ready = 1'b0;
        tick();
        tick();
        chk("abort_stall_pre", stall, 1);
        #2;
        rst = 1'b1; valid = 1'b0;
        #1;
        chk("abort_en", en, 0);
        chk("abort_addr", waddr, 0);
        chk("abort_data", wdata, 0);
        chk("abort_mis", mis, 0);
        chk("abort_tmo", tmo, 0);
        chk("abort_stall", stall, 0);
        ready = 1'b1; mem = 32'h0BAD_0BAD;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_post_en%0d", i), en, 0);
        end

        // Memory never answers: timeout after MEM_TO waiting cycles
        valid = 1'b1; rd = 1'b1; m2r = 1'b1; rw = 1'b1; addr = 5'd12; size = 2'd0; alu = 32'h0; ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            valid = (i <= MEM_TO);
            mem = $urandom;
            #1 chk($sformatf("tmo_stall%0d", i), stall, (i <= MEM_TO));
            tick();
            chk($sformatf("tmo_en%0d", i), en, 0);
            chk($sformatf("tmo_flag%0d", i), tmo, (i >= MEM_TO));
        end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("tmo_cleared", tmo, 0);
        tick();

        // Randomized transactions against the reference model
        sticky = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                valid = 1'b0; ready = 1'($urandom); mem = $urandom;
                #1 chk("rnd_gap_stall", stall, 0);
                tick();
                chk("rnd_gap_en", en, 0);
                chk("rnd_gap_mis", mis, 0);
            end
            rd   = 1'($urandom);
            m2r  = rd ? ($urandom_range(0, 3) != 0) : 1'($urandom);
            rw   = ($urandom_range(0, 5) != 0);
            addr = 5'($urandom);
            size = 2'($urandom);
            uns  = 1'($urandom);
            alu  = $urandom;
            final_mem = $urandom;
            k     = rd ? $urandom_range(0, MEM_TO + 1) : 0;
            timed = rd && (k > MEM_TO);
            ncyc  = timed ? MEM_TO + 1 : k + 1;
            model(alu, final_mem, size, uns, m2r, rw, addr, e_en, e_mis, e_data);
            for (int c = 0; c < ncyc; c++) begin
                valid = 1'b1;
                ready = rd ? (c >= k) : 1'($urandom);
                mem   = (c == ncyc - 1) ? final_mem : $urandom;
                #1 chk("rnd_stall", stall, (rd && k > 0));
                tick();
                if (c < ncyc - 1) chk("rnd_wait_en", en, 0);
            end
            valid = 1'b0;
            if (timed) sticky = 1'b1;
            chk("rnd_en", en, timed ? 1'b0 : e_en);
            chk("rnd_mis", mis, timed ? 1'b0 : e_mis);
            chk("rnd_tmo", tmo, sticky);
            if (!timed && e_en) begin
                chk("rnd_addr", waddr, addr);
                chk("rnd_data", wdata, e_data);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
